hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide engine that owns the HI/LO register pair for the pipelined MIPS core. It executes the HI/LO operations the ALU controller decodes: MULT, MULTU, MADD, MSUB, DIV, DIVU, MTHI and MTLO. It sits beside the EX-stage ALU. It raises Stall so the hazard unit holds the pipeline while a result is pending.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be even.
BITS_PER_CYCLE, 1, iteration bits retired per CALC cycle; legal values 1, 2, 4; WIDTH % BITS_PER_CYCLE == 0.
ITER, WIDTH/BITS_PER_CYCLE, derived localparam, number of CALC cycles.

Ports:
Clk  in  1  system clock; all state updates on rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Start  in  1  op request; sampled only in IDLE.
Op  in  4  operation code (muldiv_pkg encoding).
OperandA  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source).
OperandB  in  WIDTH  rt value (divisor / multiplier).
Flush  in  1  cancel in-flight op (branch/JR flush).
HLRead  in  1  MFHI/MFLO present in EX.
Busy  out  1  high in CALC and FIX.
Done  out  1  one-cycle pulse when HI/LO have taken a multi-cycle result.
DivZero  out  1  one-cycle pulse, coincident with Done, for DIV/DIVU with OperandB==0.
Stall  out  1  combinational: Busy & (Start | HLRead).
Hi  out  WIDTH  HI register.
Lo  out  WIDTH  LO register.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset_n low, including mid-operation: state is IDLE. Hi, Lo, Busy, Done and DivZero are 0. Iteration counters and working registers are cleared.
- FSM: IDLE -> CALC -> FIX -> IDLE.
- IDLE, Start=1, Op MTHI or MTLO: Hi or Lo takes OperandA on the sampling edge. No Busy and no Done. State stays IDLE.
- IDLE, Start=1, multi-cycle op: operands are latched as magnitudes and result signs are recorded (signed ops only). State moves to CALC with count=0.
- CALC: each cycle performs BITS_PER_CYCLE shift-add (multiply) or restoring-subtract (divide) steps. After ITER cycles the state moves to FIX.
- FIX, one cycle: applies sign correction and writes the result to Hi/Lo on the FIX->IDLE edge.
  - Multiply: {Hi,Lo} = 2*WIDTH product.
  - MADD: {Hi,Lo} = {Hi,Lo} + product, modulo 2^(2*WIDTH).
  - MSUB: {Hi,Lo} = {Hi,Lo} - product, modulo 2^(2*WIDTH).
  - MADD/MSUB are signed products.
  - Divide: Lo = quotient truncated toward zero; Hi = remainder carrying the sign of the dividend.
- Divide by zero: Lo = all ones, Hi = OperandA unmodified; DivZero pulses.
- Latency: Start sampled at edge E. Busy is high for ITER+1 cycles. New Hi/Lo are visible after edge E+ITER+1. Done is high for the cycle that follows.
- Start while Busy is ignored, including MTHI/MTLO; Stall tells the pipeline to hold it.
- Flush while Busy: return to IDLE on the next edge. Hi/Lo are unchanged and there is no Done.
- Flush with Start in IDLE: Flush wins and the op is not accepted.
- Flush during FIX: cancel; the write is suppressed.
- Undefined Op codes with Start are ignored; no state change.
- Done and DivZero are registered outputs.

Decomposition:
- muldiv_pkg: Op encodings MD_MULT=0, MD_MULTU=1, MD_MADD=2, MD_MSUB=3, MD_DIV=4, MD_DIVU=5, MD_MTHI=6, MD_MTLO=7; FSM state enum; is_signed/is_div helper functions.
- Sub-module muldiv_step: combinational single-bit iteration step (add-shift or restore-subtract). It is instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
(Defaults WIDTH=32, BITS_PER_CYCLE=1, ITER=32.)
- MULT A=0xFFFFFFFF, B=2 -> after 33 Busy cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFFE, Done 1 cycle. MULTU with the same operands -> Hi=0x00000001, Lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=7, DivZero and Done pulse together.
- MTLO 0xFFFFFFFF, MTHI 0, then MADD 1*1 -> Hi=1, Lo=0. From Hi=Lo=0, MSUB 1*1 -> Hi=Lo=0xFFFFFFFF.
- DIV in flight, Flush at CALC cycle 10 -> Busy low after next edge, Hi/Lo unchanged, no Done. Repeat with Flush during FIX -> same result.
- Busy with Start=1 (MTHI 0x55) and HLRead=1 -> Stall=1, Hi unchanged. After Done, MFHI-path read returns the multi-cycle result.
- Reset_n pulsed low mid-CALC -> Hi=Lo=0, Busy=0 immediately (asynchronous). Rerun with BITS_PER_CYCLE=4 -> Busy 9 cycles, same numeric results.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and op-classification helpers.
package muldiv_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_MADD  = 4'd2,
        MD_MSUB  = 4'd3,
        MD_DIV   = 4'd4,
        MD_DIVU  = 4'd5,
        MD_MTHI  = 4'd6,
        MD_MTLO  = 4'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_multi(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
               (op == MD_MSUB) || (op == MD_DIV)   || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             Flush;
    logic             HLRead;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic             Stall;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB, Flush, HLRead,
        input  Busy, Done, DivZero, Stall, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, Flush, HLRead,
        output Busy, Done, DivZero, Stall, Hi, Lo
    );
endinterface

// File: rtl/hilo_muldiv_unit_step.sv
// One radix-2 iteration on the {hi,lo} working pair: shift-add for multiply,
// restoring shift-subtract for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] diff;

    always_comb begin
        addend = lo_i[0] ? m_i : {WIDTH{1'b0}};
        sum    = {1'b0, hi_i} + {1'b0, addend};
        shl    = {hi_i, lo_i[WIDTH-1]};
        // Remainder stays below the divisor, so the difference always fits WIDTH bits.
        diff   = shl[WIDTH-1:0] - m_i;
        if (is_div_i) begin
            if (shl >= {1'b0, m_i}) begin
                hi_o = diff;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = shl[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the HI/LO pair; works on magnitudes
// during CALC and applies signs / accumulation in the single FIX cycle.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic               Clk,
    input logic               Reset_n,
    hilo_muldiv_unit_if.slave bus
);
    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, m_q, m_d, araw_q, araw_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             negp_q, negp_d, negr_q, negr_d, dzf_q, dzf_d;
    logic             done_q, done_d, dz_q, dz_d;

    logic [BITS_PER_CYCLE:0][WIDTH-1:0] hi_c, lo_c;
    logic             div_op;

    assign div_op  = is_div(op_q);
    assign hi_c[0] = wh_q;
    assign lo_c[0] = wl_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_div_i (div_op),
            .hi_i     (hi_c[g]),
            .lo_i     (lo_c[g]),
            .m_i      (m_q),
            .hi_o     (hi_c[g+1]),
            .lo_o     (lo_c[g+1])
        );
    end

    logic             sa, sb;
    logic [WIDTH-1:0] amag, bmag, quo, rem;
    logic [2*WIDTH-1:0] prod_s;

    always_comb begin
        sa     = is_signed(bus.Op) & bus.OperandA[WIDTH-1];
        sb     = is_signed(bus.Op) & bus.OperandB[WIDTH-1];
        amag   = sa ? -bus.OperandA : bus.OperandA;
        bmag   = sb ? -bus.OperandB : bus.OperandB;
        prod_s = negp_q ? -{wh_q, wl_q} : {wh_q, wl_q};
        quo    = negp_q ? -wl_q : wl_q;
        rem    = negr_q ? -wh_q : wh_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        wh_d    = wh_q;
        wl_d    = wl_q;
        m_d     = m_q;
        araw_d  = araw_q;
        negp_d  = negp_q;
        negr_d  = negr_q;
        dzf_d   = dzf_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start && !bus.Flush) begin
                    if (bus.Op == MD_MTHI) begin
                        hi_d = bus.OperandA;
                    end else if (bus.Op == MD_MTLO) begin
                        lo_d = bus.OperandA;
                    end else if (is_multi(bus.Op)) begin
                        state_d = ST_CALC;
                        cnt_d   = '0;
                        op_d    = md_op_e'(bus.Op);
                        araw_d  = bus.OperandA;
                        negp_d  = sa ^ sb;
                        negr_d  = sa;
                        dzf_d   = is_div(bus.Op) && (bus.OperandB == '0);
                        wh_d    = '0;
                        // Divide shifts the dividend out of lo; multiply shifts the multiplier out.
                        wl_d    = is_div(bus.Op) ? amag : bmag;
                        m_d     = is_div(bus.Op) ? bmag : amag;
                    end
                end
            end
            ST_CALC: begin
                if (bus.Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    wh_d  = hi_c[BITS_PER_CYCLE];
                    wl_d  = lo_c[BITS_PER_CYCLE];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.Flush) begin
                    done_d = 1'b1;
                    dz_d   = dzf_q;
                    case (op_q)
                        MD_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        MD_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
                        MD_DIV, MD_DIVU: begin
                            hi_d = dzf_q ? araw_q : rem;
                            lo_d = dzf_q ? {WIDTH{1'b1}} : quo;
                        end
                        default: {hi_d, lo_d} = prod_s;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            wh_q    <= '0;
            wl_q    <= '0;
            m_q     <= '0;
            araw_q  <= '0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            dzf_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wh_q    <= wh_d;
            wl_q    <= wl_d;
            m_q     <= m_d;
            araw_q  <= araw_d;
            negp_q  <= negp_d;
            negr_q  <= negr_d;
            dzf_q   <= dzf_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.Busy    = (state_q != ST_IDLE);
    assign bus.Stall   = bus.Busy & (bus.Start | bus.HLRead);
    assign bus.Done    = done_q;
    assign bus.DivZero = dz_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: a vector table of ops plus hand-written
// flush / stall / reset sequences, and a radix-16 instance for latency.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
    hilo_muldiv_unit_if #(.WIDTH(W)) bus4 ();

    hilo_muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut (
        .Clk(clk), .Reset_n(rst_n), .bus(bus));
    hilo_muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
        .Clk(clk), .Reset_n(rst_n), .bus(bus4));

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        pre;
        logic [31:0] phi, plo;
        logic [31:0] ehi, elo;
        logic        edz;
        string       name;
    } vec_t;

    vec_t tbl[15];

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.OperandA = v;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.Busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run4(input vec_t v);
        int n;
        @(negedge clk);
        bus4.Start = 1'b1; bus4.Op = v.op; bus4.OperandA = v.a; bus4.OperandB = v.b;
        @(negedge clk);
        bus4.Start = 1'b0;
        n = 0;
        while (bus4.Busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({v.name, "/r4.busy"}, 64'(n), 64'd9);
        chk({v.name, "/r4.done"}, 64'(bus4.Done), 64'd1);
        chk({v.name, "/r4.hi"}, 64'(bus4.Hi), 64'(v.ehi));
        chk({v.name, "/r4.lo"}, 64'(bus4.Lo), 64'(v.elo));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, dones;
        logic [31:0] hi_ref, lo_ref;

        tbl[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h2,        1'b0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mult_neg"};
        tbl[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h2,        1'b0, 0, 0, 32'h00000001, 32'hFFFFFFFE, 1'b0, "multu"};
        tbl[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        1'b0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg"};
        tbl[3]  = '{MD_DIVU,  32'h7,        32'h0,        1'b0, 0, 0, 32'h00000007, 32'hFFFFFFFF, 1'b1, "divu_zero"};
        tbl[4]  = '{MD_MADD,  32'h1,        32'h1,        1'b1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, "madd_carry"};
        tbl[5]  = '{MD_MSUB,  32'h1,        32'h1,        1'b1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "msub_borrow"};
        tbl[6]  = '{MD_DIV,   32'h7,        32'hFFFFFFFE, 1'b0, 0, 0, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_negdivisor"};
        tbl[7]  = '{MD_DIVU,  32'd100,      32'd7,        1'b0, 0, 0, 32'd2, 32'd14, 1'b0, "divu_100_7"};
        tbl[8]  = '{MD_MULT,  32'h80000000, 32'h80000000, 1'b0, 0, 0, 32'h40000000, 32'h0, 1'b0, "mult_minmin"};
        tbl[9]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
        tbl[10] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0, 32'h0, 32'h80000000, 1'b0, "div_ovf"};
        tbl[11] = '{MD_DIV,   32'hFFFFFFFB, 32'h0,        1'b0, 0, 0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, "div_zero_signed"};
        tbl[12] = '{MD_MADD,  32'hFFFFFFFD, 32'h4,        1'b1, 32'h0, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "madd_neg"};
        tbl[13] = '{MD_MSUB,  32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 32'h0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "msub_negneg"};
        tbl[14] = '{MD_MULTU, 32'h12345678, 32'h10,       1'b0, 0, 0, 32'h00000001, 32'h23456780, 1'b0, "multu_shift"};

        bus.Start = 0; bus.Op = 0; bus.OperandA = 0; bus.OperandB = 0; bus.Flush = 0; bus.HLRead = 0;
        bus4.Start = 0; bus4.Op = 0; bus4.OperandA = 0; bus4.OperandB = 0; bus4.Flush = 0; bus4.HLRead = 0;

        #12;
        chk("reset.hi", 64'(bus.Hi), 64'd0);
        chk("reset.lo", 64'(bus.Lo), 64'd0);
        chk("reset.busy", 64'(bus.Busy), 64'd0);
        chk("reset.done", 64'(bus.Done), 64'd0);
        chk("reset.divzero", 64'(bus.DivZero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].pre) begin
                mt(MD_MTHI, tbl[i].phi);
                mt(MD_MTLO, tbl[i].plo);
                chk({tbl[i].name, ".pre_hi"}, 64'(bus.Hi), 64'(tbl[i].phi));
                chk({tbl[i].name, ".pre_lo"}, 64'(bus.Lo), 64'(tbl[i].plo));
            end
            start_op(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_idle(n);
            chk({tbl[i].name, ".busy"}, 64'(n), 64'd33);
            chk({tbl[i].name, ".done"}, 64'(bus.Done), 64'd1);
            chk({tbl[i].name, ".divzero"}, 64'(bus.DivZero), 64'(tbl[i].edz));
            chk({tbl[i].name, ".hi"}, 64'(bus.Hi), 64'(tbl[i].ehi));
            chk({tbl[i].name, ".lo"}, 64'(bus.Lo), 64'(tbl[i].elo));
            @(negedge clk);
            chk({tbl[i].name, ".done_pulse"}, 64'(bus.Done), 64'd0);
        end
        hi_ref = 32'h00000001;
        lo_ref = 32'h23456780;

        // Flush in CALC cycle 10
        start_op(MD_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        chk("flush_calc.busy", 64'(bus.Busy), 64'd0);
        dones = 0;
        repeat (40) begin
            if (bus.Done) dones++;
            @(negedge clk);
        end
        chk("flush_calc.no_done", 64'(dones), 64'd0);
        chk("flush_calc.hi", 64'(bus.Hi), 64'(hi_ref));
        chk("flush_calc.lo", 64'(bus.Lo), 64'(lo_ref));

        // Flush in FIX
        start_op(MD_DIV, 32'd1000, 32'd3);
        repeat (32) @(negedge clk);
        chk("flush_fix.busy_in_fix", 64'(bus.Busy), 64'd1);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        chk("flush_fix.busy", 64'(bus.Busy), 64'd0);
        chk("flush_fix.done", 64'(bus.Done), 64'd0);
        chk("flush_fix.hi", 64'(bus.Hi), 64'(hi_ref));
        chk("flush_fix.lo", 64'(bus.Lo), 64'(lo_ref));

        // Flush beats Start in IDLE; undefined op ignored
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = MD_MTHI; bus.OperandA = 32'hAB; bus.Flush = 1'b1;
        @(negedge clk);
        bus.Op = MD_MULT;
        @(negedge clk);
        bus.Start = 1'b0; bus.Flush = 1'b0;
        chk("flush_idle.busy", 64'(bus.Busy), 64'd0);
        chk("flush_idle.hi", 64'(bus.Hi), 64'(hi_ref));
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 4'hC; bus.OperandA = 32'h77;
        @(negedge clk);
        bus.Start = 1'b0;
        chk("undef_op.busy", 64'(bus.Busy), 64'd0);
        chk("undef_op.hi", 64'(bus.Hi), 64'(hi_ref));
        chk("undef_op.lo", 64'(bus.Lo), 64'(lo_ref));

        // Stall while busy; MTHI during busy must be dropped
        start_op(MD_MULT, 32'hFFFFFFFD, 32'd5);
        bus.Start = 1'b1; bus.Op = MD_MTHI; bus.OperandA = 32'h55; bus.HLRead = 1'b1;
        #1;
        chk("stall.asserted", 64'(bus.Stall), 64'd1);
        @(negedge clk);
        bus.Start = 1'b0; bus.HLRead = 1'b0;
        #1;
        chk("stall.released", 64'(bus.Stall), 64'd0);
        chk("stall.hi_held", 64'(bus.Hi), 64'(hi_ref));
        wait_idle(n);
        chk("stall.done", 64'(bus.Done), 64'd1);
        bus.HLRead = 1'b1;
        #1;
        chk("stall.idle_read", 64'(bus.Stall), 64'd0);
        chk("stall.mfhi", 64'(bus.Hi), 64'hFFFFFFFF);
        chk("stall.mflo", 64'(bus.Lo), 64'hFFFFFFF1);
        bus.HLRead = 1'b0;

        // Asynchronous reset in the middle of CALC
        start_op(MD_DIVU, 32'd50, 32'd5);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.hi", 64'(bus.Hi), 64'd0);
        chk("areset.lo", 64'(bus.Lo), 64'd0);
        chk("areset.busy", 64'(bus.Busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run4(tbl[0]);
        run4(tbl[2]);
        run4(tbl[9]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
